// File: rtl/sb_3320_path_sequencer_pkg.sv
// Shared definitions for the path sequencer and the direction lookup.
package sb_3320_path_sequencer_pkg;

   localparam int NODE_W = 5;
   localparam logic [NODE_W-1:0] START_NODE = 5'd27;

   // Direction codes, identical on both sides of the lookup interface.
   localparam logic [2:0] DIR_STOP  = 3'b000;
   localparam logic [2:0] DIR_FWD   = 3'b001;
   localparam logic [2:0] DIR_LEFT  = 3'b010;
   localparam logic [2:0] DIR_RIGHT = 3'b011;
   localparam logic [2:0] DIR_UTURN = 3'b100;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READY,
      ST_LOOKUP,
      ST_ISSUE,
      ST_TRAVEL,
      ST_FINAL
   } state_t;

endpackage

// File: rtl/sb_3320_path_buffer.sv
// Path node storage: one write port, three combinational reads around an index.
module sb_3320_path_buffer
   import sb_3320_path_sequencer_pkg::*;
#(
   parameter int MAX_LEN = 32,
   localparam int IDX_W  = $clog2(MAX_LEN)
) (
   input  logic              clk_i,
   input  logic              wr_en_i,
   input  logic [IDX_W-1:0]  wr_addr_i,
   input  logic [NODE_W-1:0] wr_node_i,
   input  logic [IDX_W-1:0]  rd_idx_i,
   output logic [NODE_W-1:0] rd_prev_o,
   output logic [NODE_W-1:0] rd_curr_o,
   output logic [NODE_W-1:0] rd_next_o
);

   logic [NODE_W-1:0] mem_q [MAX_LEN];
   logic [IDX_W-1:0]  idx_prev;
   logic [IDX_W-1:0]  idx_next;

   // Contents survive reset; a new load simply overwrites from slot 0.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) mem_q[wr_addr_i] <= wr_node_i;
   end

   // Neighbour indices wrap; the sequencer substitutes START_NODE at index 0
   // and never consumes the next slot past the final node.
   always_comb begin
      idx_prev  = rd_idx_i - IDX_W'(1);
      idx_next  = rd_idx_i + IDX_W'(1);
      rd_prev_o = mem_q[idx_prev];
      rd_curr_o = mem_q[rd_idx_i];
      rd_next_o = mem_q[idx_next];
   end

endmodule

// File: rtl/sb_3320_path_sequencer.sv
// Walks a loaded node path, feeds (prev, curr, next) to the direction lookup
// and hands each resulting direction to the motion controller.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | accepting path nodes into the buffer
//   ST_READY  | path complete, waiting for start_run
//   ST_LOOKUP | triple presented, down-counting the lookup latency
//   ST_ISSUE  | direction command offered, waiting for cmd_ready
//   ST_TRAVEL | command taken, waiting for arrival at the next node
//   ST_FINAL  | stop command offered; acceptance ends the run
module sb_3320_path_sequencer
   import sb_3320_path_sequencer_pkg::*;
#(
   parameter int MAX_LEN    = 32,
   parameter int LOOKUP_LAT = 2
) (
   input  logic              clk_50,
   input  logic              reset,
   input  logic              load_valid,
   input  logic [NODE_W-1:0] load_node,
   input  logic              load_last,
   output logic              load_ready,
   input  logic              start_run,
   input  logic              node_event,
   output logic              lut_start,
   output logic [NODE_W-1:0] prev_node,
   output logic [NODE_W-1:0] curr_node,
   output logic [NODE_W-1:0] next_node,
   input  logic [2:0]        dir_in,
   output logic              cmd_valid,
   output logic [2:0]        cmd_dir,
   input  logic              cmd_ready,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [5:0]        path_len
);

   localparam int IDX_W  = $clog2(MAX_LEN);
   localparam int WAIT_W = $clog2(LOOKUP_LAT + 1);

   state_t            state_q, state_d;
   logic [5:0]        path_len_q, path_len_d;
   logic [IDX_W-1:0]  index_q, index_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              cmd_valid_q, cmd_valid_d;
   logic [2:0]        cmd_dir_q, cmd_dir_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              error_q, error_d;
   logic [NODE_W-1:0] prev_q, prev_d, curr_q, curr_d, next_q, next_d;
   logic              lut_start_q;

   logic              load_ready_c;
   logic              load_accept;
   logic              load_triple;
   logic [NODE_W-1:0] rd_prev, rd_curr, rd_next;

   // Buffer reads follow the index being entered, so the triple is
   // captured on the same edge that moves into ST_LOOKUP.
   sb_3320_path_buffer #(.MAX_LEN(MAX_LEN)) u_buf (
      .clk_i     (clk_50),
      .wr_en_i   (load_accept),
      .wr_addr_i (path_len_q[IDX_W-1:0]),
      .wr_node_i (load_node),
      .rd_idx_i  (index_d),
      .rd_prev_o (rd_prev),
      .rd_curr_o (rd_curr),
      .rd_next_o (rd_next)
   );

   // State, counters and registered outputs.
   always_ff @(posedge clk_50) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         path_len_q  <= '0;
         index_q     <= '0;
         wait_q      <= '0;
         cmd_valid_q <= 1'b0;
         cmd_dir_q   <= DIR_STOP;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         prev_q      <= START_NODE;
         curr_q      <= START_NODE;
         next_q      <= START_NODE;
         lut_start_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         path_len_q  <= path_len_d;
         index_q     <= index_d;
         wait_q      <= wait_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_dir_q   <= cmd_dir_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
         prev_q      <= prev_d;
         curr_q      <= curr_d;
         next_q      <= next_d;
         lut_start_q <= 1'b1;
      end
   end

   // Next-state and output decisions.
   always_comb begin
      state_d     = state_q;
      path_len_d  = path_len_q;
      index_d     = index_q;
      wait_d      = wait_q;
      cmd_valid_d = cmd_valid_q;
      cmd_dir_d   = cmd_dir_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      error_d     = error_q;
      prev_d      = prev_q;
      curr_d      = curr_q;
      next_d      = next_q;
      load_triple = 1'b0;

      load_ready_c = !reset && (state_q == ST_IDLE) && (path_len_q < 6'(MAX_LEN));
      load_accept  = load_valid && load_ready_c;

      // An arrival outside ST_TRAVEL means the bot outran the sequencer.
      if (node_event && (state_q != ST_TRAVEL)) error_d = 1'b1;

      case (state_q)
         ST_IDLE: begin
            if (load_accept) begin
               path_len_d = path_len_q + 6'd1;
               if (load_last) begin
                  state_d = ST_READY;
               end else if (path_len_q + 6'd1 == 6'(MAX_LEN)) begin
                  state_d = ST_READY;
                  error_d = 1'b1;
               end
            end
         end
         ST_READY: begin
            if (start_run) begin
               busy_d = 1'b1;
               if (path_len_q == 6'd1) begin
                  cmd_dir_d   = DIR_STOP;
                  cmd_valid_d = 1'b1;
                  state_d     = ST_FINAL;
               end else begin
                  index_d     = '0;
                  wait_d      = WAIT_W'(LOOKUP_LAT);
                  load_triple = 1'b1;
                  state_d     = ST_LOOKUP;
               end
            end
         end
         ST_LOOKUP: begin
            if (wait_q == '0) begin
               cmd_valid_d = 1'b1;
               if (dir_in == DIR_STOP) begin
                  error_d   = 1'b1;
                  cmd_dir_d = DIR_STOP;
                  state_d   = ST_FINAL;
               end else begin
                  cmd_dir_d = dir_in;
                  state_d   = ST_ISSUE;
               end
            end else begin
               wait_d = wait_q - WAIT_W'(1);
            end
         end
         ST_ISSUE: begin
            if (cmd_ready) begin
               cmd_valid_d = 1'b0;
               state_d     = ST_TRAVEL;
            end
         end
         ST_TRAVEL: begin
            if (node_event) begin
               index_d = index_q + IDX_W'(1);
               if (6'(index_q) + 6'd1 == path_len_q - 6'd1) begin
                  cmd_dir_d   = DIR_STOP;
                  cmd_valid_d = 1'b1;
                  state_d     = ST_FINAL;
               end else begin
                  wait_d      = WAIT_W'(LOOKUP_LAT);
                  load_triple = 1'b1;
                  state_d     = ST_LOOKUP;
               end
            end
         end
         ST_FINAL: begin
            if (cmd_ready) begin
               cmd_valid_d = 1'b0;
               done_d      = 1'b1;
               busy_d      = 1'b0;
               path_len_d  = '0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (load_triple) begin
         prev_d = (index_d == '0) ? START_NODE : rd_prev;
         curr_d = rd_curr;
         next_d = rd_next;
      end
   end

   assign load_ready = load_ready_c;
   assign lut_start  = lut_start_q;
   assign prev_node  = prev_q;
   assign curr_node  = curr_q;
   assign next_node  = next_q;
   assign cmd_valid  = cmd_valid_q;
   assign cmd_dir    = cmd_dir_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign error      = error_q;
   assign path_len   = path_len_q;

endmodule

// File: tb/tb_sb_3320_path_sequencer.sv
// Bench for sb_3320_path_sequencer: a small direction table stands in for the
// lookup, and a path-level model predicts the command stream.
module tb_sb_3320_path_sequencer;

   localparam int LAT = 2;
   localparam logic [4:0] START = 5'd27;

   logic       clk_50;
   logic       reset;
   logic       load_valid;
   logic [4:0] load_node;
   logic       load_last;
   logic       load_ready;
   logic       start_run;
   logic       node_event;
   logic       lut_start;
   logic [4:0] prev_node, curr_node, next_node;
   logic [2:0] dir_in;
   logic       cmd_valid;
   logic [2:0] cmd_dir;
   logic       cmd_ready;
   logic       busy, done, error;
   logic [5:0] path_len;

   sb_3320_path_sequencer #(.MAX_LEN(32), .LOOKUP_LAT(LAT)) dut (
      .clk_50(clk_50), .reset(reset),
      .load_valid(load_valid), .load_node(load_node), .load_last(load_last),
      .load_ready(load_ready), .start_run(start_run), .node_event(node_event),
      .lut_start(lut_start), .prev_node(prev_node), .curr_node(curr_node),
      .next_node(next_node), .dir_in(dir_in), .cmd_valid(cmd_valid),
      .cmd_dir(cmd_dir), .cmd_ready(cmd_ready), .busy(busy), .done(done),
      .error(error), .path_len(path_len)
   );

   initial clk_50 = 1'b0;
   always #5 clk_50 = ~clk_50;

   // Direction table known to the bench.
   function automatic logic [2:0] lut_f(input logic [4:0] p, input logic [4:0] c,
                                        input logic [4:0] n);
      if (p == 5'd27 && c == 5'd0 && n == 5'd1) return 3'b001;
      if (p == 5'd0  && c == 5'd1 && n == 5'd2) return 3'b011;
      if (p == 5'd1  && c == 5'd2 && n == 5'd5) return 3'b001;
      return 3'b000;
   endfunction

   // Lookup with two register stages: valid LAT cycles after a triple change.
   logic [2:0] st1 = 3'b000, st2 = 3'b000;
   always @(posedge clk_50) begin
      st1 <= lut_start ? lut_f(prev_node, curr_node, next_node) : 3'b000;
      st2 <= st1;
   end
   assign dir_in = st2;

   typedef struct packed {
      logic [2:0] dir;
      logic [4:0] p;
      logic [4:0] c;
      logic [4:0] n;
      logic       chk;
   } exp_t;

   exp_t       exp_q[$];
   logic [4:0] path_m[$];
   int         n_vec = 0;
   int         n_err = 0;
   int         done_cnt = 0;
   bit         frozen = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk_50);
      #1;
   endtask

   // Path-level model: one command per interior lookup, then a stop; an
   // unmapped triple ends the run with a stop on that triple.
   function automatic bit build_expect();
      exp_t e;
      exp_q.delete();
      if (path_m.size() == 1) begin
         e = '{dir: 3'b000, p: 5'd0, c: 5'd0, n: 5'd0, chk: 1'b0};
         exp_q.push_back(e);
         return 1'b0;
      end
      for (int i = 0; i < path_m.size() - 1; i++) begin
         e.p   = (i == 0) ? START : path_m[i-1];
         e.c   = path_m[i];
         e.n   = path_m[i+1];
         e.dir = lut_f(e.p, e.c, e.n);
         e.chk = 1'b1;
         exp_q.push_back(e);
         if (e.dir == 3'b000) return 1'b1;
      end
      e = '{dir: 3'b000, p: 5'd0, c: 5'd0, n: 5'd0, chk: 1'b0};
      exp_q.push_back(e);
      return 1'b0;
   endfunction

   // Per-cycle compare: handshake stability, command order and contents.
   initial begin
      exp_t e;
      bit   pend = 0;
      logic [2:0] pend_dir = 3'b000;
      bit   rst_prev = 1;
      forever begin
         @(negedge clk_50);
         if (reset) begin
            pend = 0;
         end else begin
            if (pend) begin
               chk("hold_valid", cmd_valid, 1);
               chk("hold_dir", cmd_dir, pend_dir);
            end
            if (cmd_valid && cmd_ready) begin
               chk("cmd_expected", exp_q.size() > 0, 1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  chk("cmd_dir", cmd_dir, e.dir);
                  if (e.chk) chk("cmd_triple", {prev_node, curr_node, next_node}, {e.p, e.c, e.n});
               end
            end
            pend     = cmd_valid && !cmd_ready;
            pend_dir = cmd_dir;
            if (done) done_cnt++;
            if (frozen) chk("frozen_triple", {prev_node, curr_node, next_node}, {START, START, START});
            if (!rst_prev) chk("lut_start_on", lut_start, 1);
         end
         rst_prev = reset;
      end
   end

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      chk("rst_load_ready", load_ready, 0);
      chk("rst_lut_start", lut_start, 0);
      reset = 1'b0;
      tick();
      chk("post_lut_start", lut_start, 1);
      chk("post_cmd_valid", cmd_valid, 0);
      chk("post_flags", {busy, done, error}, 3'b000);
      chk("post_path_len", path_len, 0);
      chk("post_triple", {prev_node, curr_node, next_node}, {START, START, START});
      chk("post_load_ready", load_ready, 1);
   endtask

   task automatic load_path(input bit with_last);
      for (int i = 0; i < path_m.size(); i++) begin
         chk("load_ready_before", load_ready, 1);
         load_valid = 1'b1;
         load_node  = path_m[i];
         load_last  = with_last && (i == path_m.size() - 1);
         tick();
      end
      load_valid = 1'b0;
      load_last  = 1'b0;
      chk("loaded_len", path_len, path_m.size());
      chk("loaded_ready_low", load_ready, 0);
   endtask

   task automatic run_path(input int delay, input bit inject, input int abort_after,
                           input logic exp_err);
      int n;
      int k;
      int base;
      bit last;
      base = done_cnt;
      k = 0;
      start_run = 1'b1;
      tick();
      start_run = 1'b0;
      chk("busy_after_start", busy, 1);
      if (inject) begin
         node_event = 1'b1;
         tick();
         node_event = 1'b0;
      end
      n = 0;
      while (!cmd_valid && n < 40) begin tick(); n++; end
      if (!inject) chk("first_latency", n, exp_q[0].chk ? LAT + 1 : 0);
      while (exp_q.size() > 0) begin
         n = 0;
         while (!cmd_valid && n < 40) begin tick(); n++; end
         if (!cmd_valid) begin
            chk("cmd_timeout", cmd_valid, 1);
            exp_q.delete();
            return;
         end
         last = (exp_q.size() == 1);
         repeat (delay) tick();
         cmd_ready = 1'b1;
         tick();
         cmd_ready = 1'b0;
         k++;
         if (last) break;
         if (k == abort_after) return;
         repeat (2) tick();
         chk("travel_idle", cmd_valid, 0);
         node_event = 1'b1;
         tick();
         node_event = 1'b0;
         n = 0;
         while (!cmd_valid && n < 40) begin tick(); n++; end
         if (exp_q.size() > 0)
            chk("event_latency", n, exp_q[0].chk ? LAT + 1 : 0);
      end
      chk("end_path_len", path_len, 0);
      chk("end_busy", busy, 0);
      chk("end_cmd_valid", cmd_valid, 0);
      tick();
      tick();
      chk("done_pulses", done_cnt - base, 1);
      chk("end_error", error, exp_err);
   endtask

   initial begin
      bit e_err;
      int base;
      reset = 1'b1; load_valid = 1'b0; load_node = '0; load_last = 1'b0;
      start_run = 1'b0; node_event = 1'b0; cmd_ready = 1'b0;

      // Reset values, start_run ignored while idle.
      do_reset();
      start_run = 1'b1;
      tick();
      start_run = 1'b0;
      tick();
      chk("idle_start_busy", busy, 0);
      chk("idle_start_ready", load_ready, 1);

      // Four-node path, commands taken immediately.
      path_m = '{5'd0, 5'd1, 5'd2, 5'd5};
      load_path(1'b1);
      e_err = build_expect();
      chk("model_len", exp_q.size(), 4);
      chk("model_dirs", {exp_q[0].dir, exp_q[1].dir, exp_q[2].dir, exp_q[3].dir},
          {3'b001, 3'b011, 3'b001, 3'b000});
      run_path(0, 1'b0, 0, e_err);

      // Same path with a slow motion controller.
      do_reset();
      load_path(1'b1);
      e_err = build_expect();
      run_path(5, 1'b0, 0, e_err);

      // Single node: immediate stop, triple never leaves START_NODE.
      do_reset();
      path_m = '{5'd13};
      load_path(1'b1);
      e_err = build_expect();
      frozen = 1;
      run_path(0, 1'b0, 0, e_err);
      frozen = 0;

      // Full buffer without load_last, then an unmapped third triple.
      do_reset();
      path_m.delete();
      for (int i = 0; i < 32; i++) path_m.push_back(5'(i));
      load_path(1'b0);
      chk("full_error", error, 1);
      load_valid = 1'b1; load_node = 5'd9;
      tick();
      load_valid = 1'b0;
      chk("full_no_write", path_len, 32);
      e_err = build_expect();
      chk("model_unmapped", {e_err, 5'(exp_q.size()), exp_q[2].dir}, {1'b1, 5'd3, 3'b000});
      run_path(1, 1'b0, 0, 1'b1);

      // Overrun during the first lookup.
      do_reset();
      path_m = '{5'd0, 5'd1, 5'd2, 5'd5};
      load_path(1'b1);
      e_err = build_expect();
      run_path(0, 1'b1, 0, 1'b1);

      // Reset while travelling after the second command.
      do_reset();
      load_path(1'b1);
      e_err = build_expect();
      base = done_cnt;
      run_path(0, 1'b0, 2, e_err);
      tick();
      chk("abort_in_travel_busy", busy, 1);
      reset = 1'b1;
      tick();
      exp_q.delete();
      chk("abort_cmd_valid", cmd_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_path_len", path_len, 0);
      chk("abort_load_ready_rst", load_ready, 0);
      reset = 1'b0;
      tick();
      chk("abort_load_ready", load_ready, 1);
      chk("abort_error", error, 0);
      chk("abort_no_done", done_cnt - base, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
